// File: rtl/act_buf_pkg.sv
// Shared definitions for the ping-pong activation buffer: error flag bit
// positions and the address-width helper used to size the byte banks.
package act_buf_pkg;

    // Bit positions inside err_flags.
    localparam int ERR_WR_DROP = 0;
    localparam int ERR_RD_DROP = 1;
    localparam int ERR_OOB     = 2;
    localparam int ERR_W       = 3;

    // Bits needed to index one half of DEPTH words (minimum 1).
    function automatic int clog2_depth(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) w++;
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/sram_activation_pingpong_if.sv
// Producer/consumer bus of the ping-pong activation buffer. The master side
// is the DMA/writeback producer plus the PE fetch consumer; the slave side is
// the buffer itself.
interface sram_activation_pingpong_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 16
);
    // Producer side
    logic [DATA_BYTES-1:0]   wr_we;
    logic [ADDR_W-1:0]       wr_addr;
    logic [8*DATA_BYTES-1:0] wr_data;
    logic                    prod_done;
    logic                    buf_free;
    // Consumer side
    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic [8*DATA_BYTES-1:0] rd_data;
    logic                    rd_valid;
    logic                    cons_done;
    logic                    buf_ready;
    // Error reporting
    logic [2:0]              err_flags;
    logic                    err_clr;

    modport master (
        output wr_we, wr_addr, wr_data, prod_done,
        output rd_en, rd_addr, cons_done, err_clr,
        input  buf_free, rd_data, rd_valid, buf_ready, err_flags
    );

    modport slave (
        input  wr_we, wr_addr, wr_data, prod_done,
        input  rd_en, rd_addr, cons_done, err_clr,
        output buf_free, rd_data, rd_valid, buf_ready, err_flags
    );

endinterface

// File: rtl/act_byte_bank.sv
// One 8-bit byte lane of the activation buffer: simple dual-port RAM with a
// read-only port A (consumer) and a write-only port B (producer). Port A has
// a one-cycle registered read. Up to 2048 entries it is coded to land in a
// single BRAM_2048x8; larger depths fall back to a generic inferred array.
module act_byte_bank
    import act_buf_pkg::*;
#(
    parameter int DEPTH2 = 2048,   // total entries (both halves)
    parameter int BW     = 11      // address width
) (
    input  logic          clk,
    input  logic          a_en,
    input  logic [BW-1:0] a_addr,
    output logic [7:0]    a_q,
    input  logic          b_we,
    input  logic [BW-1:0] b_addr,
    input  logic [7:0]    b_d
);

    if (DEPTH2 <= 2048) begin : g_bram
        (* ram_style = "block" *) logic [7:0] mem [DEPTH2];

        // Port B write: byte lane store.
        always_ff @(posedge clk) begin
            if (b_we) mem[b_addr] <= b_d;
        end

        // Port A read: registered output, loads only on an accepted read.
        // NOTE: memory array and its read register carry no reset; a reset
        // would block block-RAM mapping and contents are undefined anyway.
        always_ff @(posedge clk) begin
            if (a_en) a_q <= mem[a_addr];
        end
    end else begin : g_array
        logic [7:0] mem [DEPTH2];

        // Port B write: byte lane store.
        always_ff @(posedge clk) begin
            if (b_we) mem[b_addr] <= b_d;
        end

        // Port A read: registered output, loads only on an accepted read.
        always_ff @(posedge clk) begin
            if (a_en) a_q <= mem[a_addr];
        end
    end

endmodule

// File: rtl/sram_activation_pingpong.sv
// Double-buffered activation SRAM. The producer fills the half selected by
// wr_sel while the consumer drains the half selected by rd_sel; prod_done /
// cons_done hand halves over. Each half is tracked by a full bit, and
// dropped or out-of-range requests raise sticky error flags.
module sram_activation_pingpong
    import act_buf_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 16     // DEPTH must be representable in ADDR_W bits
) (
    input logic                       clk,
    input logic                       rst_n,
    sram_activation_pingpong_if.slave bus
);

    localparam int AW = clog2_depth(DEPTH);   // index bits within one half
    localparam int BW = AW + 1;               // physical bank address bits
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    // Ping-pong state
    logic       wr_sel, rd_sel;
    logic [1:0] full;
    logic       wr_sel_nxt, rd_sel_nxt;
    logic [1:0] full_nxt;

    // Error state
    logic [ERR_W-1:0] err, err_nxt, err_set;

    // Read pipeline
    logic                    rd_pend;
    logic                    rd_valid_q;
    logic [8*DATA_BYTES-1:0] rd_data_q;
    logic [8*DATA_BYTES-1:0] bank_q;

    // Request qualification
    logic buf_free, buf_ready;
    logic wr_any, wr_in_range, wr_acc;
    logic rd_in_range, rd_acc;
    logic prod_acc, cons_acc;
    logic [BW-1:0] wr_bank_addr, rd_bank_addr;

    assign buf_free  = !full[wr_sel];
    assign buf_ready = full[rd_sel];

    assign wr_any      = |bus.wr_we;
    assign wr_in_range = (bus.wr_addr < DEPTH_A);
    assign wr_acc      = wr_any && buf_free && wr_in_range;

    assign rd_in_range = (bus.rd_addr < DEPTH_A);
    assign rd_acc      = bus.rd_en && buf_ready && rd_in_range;

    assign prod_acc = bus.prod_done && buf_free;
    assign cons_acc = bus.cons_done && buf_ready;

    // Accesses use the pre-toggle selects, so a write or read in the same
    // cycle as a done pulse still lands in the half being handed over.
    assign wr_bank_addr = {wr_sel, bus.wr_addr[AW-1:0]};
    assign rd_bank_addr = {rd_sel, bus.rd_addr[AW-1:0]};

    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
        act_byte_bank #(
            .DEPTH2 (2 * DEPTH),
            .BW     (BW)
        ) u_bank (
            .clk    (clk),
            .a_en   (rd_acc),
            .a_addr (rd_bank_addr),
            .a_q    (bank_q[8*i +: 8]),
            .b_we   (wr_acc && bus.wr_we[i]),
            .b_addr (wr_bank_addr),
            .b_d    (bus.wr_data[8*i +: 8])
        );
    end

    // Next-state for half ownership and sticky errors.
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        full_nxt   = full;
        wr_sel_nxt = wr_sel;
        rd_sel_nxt = rd_sel;
        err_set    = '0;

        // wr_sel and rd_sel differ whenever both accept, so the two updates
        // touch different full bits and may apply together.
        if (prod_acc) begin
            full_nxt[wr_sel] = 1'b1;
            wr_sel_nxt       = ~wr_sel;
        end
        if (cons_acc) begin
            full_nxt[rd_sel] = 1'b0;
            rd_sel_nxt       = ~rd_sel;
        end

        err_set[ERR_WR_DROP] = (wr_any && !buf_free) || (bus.prod_done && !buf_free);
        err_set[ERR_RD_DROP] = (bus.rd_en && !buf_ready) || (bus.cons_done && !buf_ready);
        err_set[ERR_OOB]     = (wr_any && !wr_in_range) || (bus.rd_en && !rd_in_range);

        // A new error in the same cycle as a clear still sticks.
        err_nxt = (bus.err_clr ? '0 : err) | err_set;
    end

    // State register for selects, full bits and error flags.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            full   <= 2'b00;
            err    <= '0;
        end else begin
            wr_sel <= wr_sel_nxt;
            rd_sel <= rd_sel_nxt;
            full   <= full_nxt;
            err    <= err_nxt;
        end
    end

    // Read pipeline: bank read at edge N, output register at edge N+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_pend    <= rd_acc;
            rd_valid_q <= rd_pend;
            if (rd_pend) rd_data_q <= bank_q;
        end
    end

    assign bus.buf_free  = buf_free;
    assign bus.buf_ready = buf_ready;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.err_flags = err;

endmodule

// File: tb/tb_sram_activation_pingpong.sv
// Directed bench for sram_activation_pingpong: fill/drain, byte enables,
// full-buffer back-pressure, simultaneous handover, errors and reset flush.
module tb_sram_activation_pingpong;

    localparam int DATA_BYTES = 4;
    localparam int DEPTH      = 1024;
    localparam int ADDR_W     = 16;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    sram_activation_pingpong_if #(.DATA_BYTES(DATA_BYTES), .ADDR_W(ADDR_W)) bus ();

    sram_activation_pingpong #(
        .DATA_BYTES (DATA_BYTES),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_we     = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.prod_done = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.cons_done = 1'b0;
        bus.err_clr   = 1'b0;
    endtask

    task automatic write_word(input int addr, input logic [31:0] data, input logic [3:0] we);
        bus.wr_addr = ADDR_W'(addr);
        bus.wr_data = data;
        bus.wr_we   = we;
        tick();
        bus.wr_we   = '0;
    endtask

    task automatic pulse_prod();
        bus.prod_done = 1'b1;
        tick();
        bus.prod_done = 1'b0;
    endtask

    task automatic pulse_cons();
        bus.cons_done = 1'b1;
        tick();
        bus.cons_done = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
    endtask

    task automatic read_word(input string tag, input int addr, input logic [31:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'(addr);
        tick();
        bus.rd_en   = 1'b0;
        check({tag, "_valid_early"}, 32'(bus.rd_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        check({tag, "_data"}, bus.rd_data, exp);
    endtask

    // Whenever a write and a read are accepted together they must hit
    // different halves.
    always @(negedge clk) begin
        if (rst_n && (|bus.wr_we) && bus.buf_free && (bus.wr_addr < ADDR_W'(DEPTH))
            && bus.rd_en && bus.buf_ready && (bus.rd_addr < ADDR_W'(DEPTH)))
            check("sel_invariant", 32'(dut.wr_sel != dut.rd_sel), 32'd1);
    end

    initial begin
        logic [31:0] exp_seq [4];
        for (int k = 0; k < 4; k++) exp_seq[k] = 32'h03020100 + 32'h04040404 * k;

        idle();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_buf_free",  32'(bus.buf_free),  32'd1);
        check("rst_buf_ready", 32'(bus.buf_ready), 32'd0);
        check("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
        check("rst_rd_data",   bus.rd_data,        32'd0);
        check("rst_err",       32'(bus.err_flags), 32'd0);

        // Fill half 0, hand over, read back-to-back.
        for (int k = 0; k < 4; k++) write_word(k, exp_seq[k], 4'hF);
        pulse_prod();
        check("seq_buf_ready", 32'(bus.buf_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            bus.rd_en   = (i < 4);
            bus.rd_addr = ADDR_W'(i);
            tick();
            check("seq_valid", 32'(bus.rd_valid), (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
            if (i >= 1 && i <= 4) check("seq_data", bus.rd_data, exp_seq[i-1]);
            check("seq_buf_free", 32'(bus.buf_free), 32'd1);
        end
        check("seq_hold_data", bus.rd_data, exp_seq[3]);
        pulse_cons();
        check("drain_buf_ready", 32'(bus.buf_ready), 32'd0);

        // Byte enables, written into half 1.
        write_word(5, 32'hAABBCCDD, 4'hF);
        write_word(5, 32'h11223344, 4'b0101);
        pulse_prod();
        read_word("be", 5, 32'hAA22CC44);
        pulse_cons();

        // Fill both halves.
        write_word(7, 32'h12345678, 4'hF);
        pulse_prod();
        pulse_prod();
        check("full_buf_free", 32'(bus.buf_free), 32'd0);
        write_word(7, 32'hDEADBEEF, 4'hF);
        check("full_wr_drop", 32'(bus.err_flags), 32'b001);
        pulse_prod();
        check("full_prod_ignored", 32'(bus.buf_free), 32'd0);
        pulse_clr();
        check("clr_err", 32'(bus.err_flags), 32'd0);
        pulse_prod();
        check("prod_drop_err", 32'(bus.err_flags), 32'b001);
        pulse_clr();
        read_word("full_mem_kept", 7, 32'h12345678);
        pulse_cons();
        check("after_cons_buf_free",  32'(bus.buf_free),  32'd1);
        check("after_cons_buf_ready", 32'(bus.buf_ready), 32'd1);
        check("after_cons_err",       32'(bus.err_flags), 32'd0);
        // Producer is now back on the drained half 0.
        write_word(8, 32'hCAFEF00D, 4'hF);
        write_word(9, 32'h55667788, 4'hF);

        // Simultaneous handover with a read and a write in the same cycle.
        bus.prod_done = 1'b1;
        bus.cons_done = 1'b1;
        bus.rd_en     = 1'b1;
        bus.rd_addr   = ADDR_W'(5);
        bus.wr_we     = 4'hF;
        bus.wr_addr   = ADDR_W'(10);
        bus.wr_data   = 32'h01020304;
        tick();
        idle();
        check("sim_buf_free",  32'(bus.buf_free),  32'd1);
        check("sim_buf_ready", 32'(bus.buf_ready), 32'd1);
        check("sim_err",       32'(bus.err_flags), 32'd0);
        tick();
        check("sim_old_valid", 32'(bus.rd_valid), 32'd1);
        check("sim_old_data",  bus.rd_data, 32'hAA22CC44);
        read_word("new_half_a", 8,  32'hCAFEF00D);
        read_word("new_half_b", 9,  32'h55667788);
        read_word("new_half_c", 10, 32'h01020304);

        // Out-of-range read.
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'(DEPTH);
        tick();
        bus.rd_en = 1'b0;
        check("oob_valid0", 32'(bus.rd_valid),  32'd0);
        check("oob_err",    32'(bus.err_flags), 32'b100);
        tick();
        check("oob_valid1", 32'(bus.rd_valid), 32'd0);
        pulse_clr();
        check("oob_clr", 32'(bus.err_flags), 32'd0);
        // Set wins over clear in the same cycle.
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'(DEPTH);
        bus.err_clr = 1'b1;
        tick();
        idle();
        check("set_over_clr", 32'(bus.err_flags), 32'b100);
        pulse_clr();
        write_word(DEPTH, 32'hFFFFFFFF, 4'hF);
        check("oob_write_err", 32'(bus.err_flags), 32'b100);
        pulse_clr();

        // Reset while a read is in flight.
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'(8);
        tick();
        bus.rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid",     32'(bus.rd_valid),  32'd0);
        check("rst_mid_buf_ready", 32'(bus.buf_ready), 32'd0);
        check("rst_mid_rd_data",   bus.rd_data,        32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            rst_n = 1'b1;
            check("rst_flush_valid", 32'(bus.rd_valid), 32'd0);
        end
        check("rst_end_buf_free", 32'(bus.buf_free),  32'd1);
        check("rst_end_err",      32'(bus.err_flags), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
